// File: rtl/cmd_frame_decoder_pkg.sv
// cmd_frame_decoder_pkg
// Shared definitions for the command-frame decoder: FSM state encoding,
// default sync marker, broadcast address and payload-length limits.
package cmd_frame_decoder_pkg;

    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        CHECK = 2'd3
    } state_t;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  BROADCAST_ID      = 8'hFF;
    localparam int unsigned MAX_PAYLOAD_LEN   = 16;
    localparam int unsigned INDEX_W           = 4;

    // Address accepted when it is ours or the broadcast address.
    function automatic logic id_match(input logic [7:0] id, input logic [7:0] own);
        return (id == own) || (id == BROADCAST_ID);
    endfunction

endpackage

// File: rtl/cmd_frame_decoder_if.sv
// cmd_frame_decoder_if
// Bundles the UART-side byte stream and the decoded-command outputs.
//   rx_data[7:0]      received byte (master -> decoder)
//   rx_done           byte-done level (master -> decoder)
//   payload           last good payload, byte 0 in bits [7:0]
//   frame_valid       one-cycle pulse, payload just updated
//   chk_err           one-cycle pulse, checksum mismatch
//   timeout_err       one-cycle pulse, inter-byte timeout
//   good_count[7:0]   good-frame counter, wraps
interface cmd_frame_decoder_if #(
    parameter int unsigned PAYLOAD_LEN = 6
);
    logic [7:0]               rx_data;
    logic                     rx_done;
    logic [8*PAYLOAD_LEN-1:0] payload;
    logic                     frame_valid;
    logic                     chk_err;
    logic                     timeout_err;
    logic [7:0]               good_count;

    modport master (
        output rx_data, rx_done,
        input  payload, frame_valid, chk_err, timeout_err, good_count
    );

    modport slave (
        input  rx_data, rx_done,
        output payload, frame_valid, chk_err, timeout_err, good_count
    );
endinterface

// File: rtl/cmd_frame_decoder_byte_strobe_edge.sv
// byte_strobe_edge
// Turns the receiver's byte-done level into a single-cycle strobe on its
// rising edge.
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_done      byte-done level from the UART receiver
//   strobe       high for the first cycle rx_done is high
module byte_strobe_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_done,
    output logic strobe
);
    logic rx_done_q;

    // Cleared in reset, so a level already high at release counts as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_done_q <= 1'b0;
        else        rx_done_q <= rx_done;
    end

    assign strobe = rx_done & ~rx_done_q;
endmodule

// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder
// Decodes frames of SYNC, ID, PAYLOAD_LEN data bytes, CHK (XOR of ID and
// data) from the UART byte stream; publishes checked payloads only.
// Optional feature macro: CMD_FRAME_TIMEOUT_EN (inter-byte timeout).
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          cmd_frame_decoder_if.slave (rx_data/rx_done in,
//                payload/frame_valid/chk_err/timeout_err/good_count out)
module cmd_frame_decoder
    import cmd_frame_decoder_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter logic [7:0]  ROBOT_ID       = 8'h03,
    parameter int unsigned PAYLOAD_LEN    = 6,
    parameter int unsigned TIMEOUT_CYCLES = 8000
) (
    input logic                 clk,
    input logic                 rst_n,
    cmd_frame_decoder_if.slave  bus
);
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(PAYLOAD_LEN - 1);

    if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > MAX_PAYLOAD_LEN || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("cmd_frame_decoder: unsupported PAYLOAD_LEN or TIMEOUT_CYCLES");
    end

    state_t                   state;
    logic                     strobe;
    logic [INDEX_W-1:0]       idx;
    logic [7:0]               xor_q;
    logic [8*PAYLOAD_LEN-1:0] shadow;
    logic [8*PAYLOAD_LEN-1:0] payload_q;
    logic                     frame_valid_q;
    logic                     chk_err_q;
    logic [7:0]               good_count_q;

`ifdef CMD_FRAME_TIMEOUT_EN
    localparam int unsigned       TIMER_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    logic [TIMER_W-1:0] timer;
    logic               timeout_err_q;
`endif

    byte_strobe_edge u_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx_done (bus.rx_done),
        .strobe  (strobe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HUNT;
            idx           <= '0;
            xor_q         <= '0;
            shadow        <= '0;
            payload_q     <= '0;
            frame_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            good_count_q  <= '0;
`ifdef CMD_FRAME_TIMEOUT_EN
            timer         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            frame_valid_q <= 1'b0;
            chk_err_q     <= 1'b0;
            if (strobe) begin
                case (state)
                    HUNT: if (bus.rx_data == SYNC_BYTE) state <= ADDR;
                    ADDR: begin
                        if (id_match(bus.rx_data, ROBOT_ID)) begin
                            state <= DATA;
                            xor_q <= bus.rx_data;
                            idx   <= '0;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    DATA: begin
                        shadow[8*idx +: 8] <= bus.rx_data;
                        xor_q <= xor_q ^ bus.rx_data;
                        if (idx == LAST_IDX) state <= CHECK;
                        else                 idx   <= idx + 1'b1;
                    end
                    CHECK: begin
                        if (bus.rx_data == xor_q) begin
                            payload_q     <= shadow;
                            frame_valid_q <= 1'b1;
                            good_count_q  <= good_count_q + 1'b1;
                        end else begin
                            chk_err_q     <= 1'b1;
                        end
                        state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
`ifdef CMD_FRAME_TIMEOUT_EN
            // A strobe in the expiry cycle wins: timer only expires when idle.
            timeout_err_q <= 1'b0;
            if (strobe || state == HUNT) begin
                timer <= '0;
            end else if (timer == TIMER_LAST) begin
                timer         <= '0;
                state         <= HUNT;
                timeout_err_q <= 1'b1;
            end else begin
                timer <= timer + 1'b1;
            end
`endif
        end
    end

    assign bus.payload     = payload_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.chk_err     = chk_err_q;
    assign bus.good_count  = good_count_q;
`ifdef CMD_FRAME_TIMEOUT_EN
    assign bus.timeout_err = timeout_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule
